ofs_jtag_tap_sink: RTL and testbench

OFS_JTAG_TAP_SINK -- requirements
Module: ofs_jtag_tap_sink

---
 rtl/ofs_jtag_tap_sink.sv | 235 +++++++++++++++++++++++
 tb/tb_ofs_jtag_tap_sink.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_jtag_tap_sink.sv
// ---------------------------------------------------------------------------
// ofs_jtag_tap_sink
//
// IEEE 1149.1 TAP controller that lives entirely in the clk domain. The JTAG
// pins arrive from a remote host and are treated as data. They are
// oversampled through 2-flop synchronizers, and tck edges are recovered by
// edge detection. clk must run at least 4x faster than tck.
//
// Instructions (4-bit IR): IDCODE=4'h1 (32-bit DR), USER=4'h8 (USER_DR_W-bit
// DR), BYPASS=4'hF (1-bit DR). Any other opcode behaves as BYPASS.
//
// Optional feature: define OFS_JTAG_TAP_SINK_TCKENA_EN to make every tck edge
// conditional on the synchronized jtag_tckena. If the macro is undefined,
// jtag_tckena is ignored.
//
// tap_state encoding:
//   0 TLR    1 RTI    2 SelDR   3 CapDR   4 ShDR    5 Ex1DR   6 PauseDR
//   7 Ex2DR  8 UpdDR  9 SelIR  10 CapIR  11 ShIR   12 Ex1IR  13 PauseIR
//  14 Ex2IR 15 UpdIR
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   jtag_tck/tms/tdi/tckena/reset   asynchronous JTAG inputs (sampled)
//   jtag_tdo        serial data out, changes after a detected tck fall
//   user_dr_rdata   value captured into the USER DR at Capture-DR
//   user_dr_wdata   USER DR contents latched at Update-DR
//   user_dr_wvalid  one-clk pulse accompanying user_dr_wdata
//   tap_state       current TAP state (debug)
// ---------------------------------------------------------------------------
module ofs_jtag_tap_sink #(
    parameter logic [31:0] IDCODE    = 32'h0000_0001,
    parameter int          USER_DR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jtag_tck,
    input  logic                 jtag_tms,
    input  logic                 jtag_tdi,
    input  logic                 jtag_tckena,
    input  logic                 jtag_reset,
    output logic                 jtag_tdo,
    input  logic [USER_DR_W-1:0] user_dr_rdata,
    output logic [USER_DR_W-1:0] user_dr_wdata,
    output logic                 user_dr_wvalid,
    output logic [3:0]           tap_state
);

    typedef enum logic [3:0] {
        ST_TLR    = 4'd0,  ST_RTI    = 4'd1,  ST_SELDR  = 4'd2,  ST_CAPDR  = 4'd3,
        ST_SHDR   = 4'd4,  ST_EX1DR  = 4'd5,  ST_PAUSDR = 4'd6,  ST_EX2DR  = 4'd7,
        ST_UPDDR  = 4'd8,  ST_SELIR  = 4'd9,  ST_CAPIR  = 4'd10, ST_SHIR   = 4'd11,
        ST_EX1IR  = 4'd12, ST_PAUSIR = 4'd13, ST_EX2IR  = 4'd14, ST_UPDIR  = 4'd15
    } tap_state_e;

    localparam logic [3:0] IR_IDCODE = 4'h1;
    localparam logic [3:0] IR_USER   = 4'h8;

    // Synchronizer lanes: [0]=tck [1]=tms [2]=tdi [3]=tckena [4]=reset
    logic [4:0]           r_sync1;
    logic [4:0]           r_sync2;
    logic                 r_tck_prev;

    tap_state_e           r_state;
    tap_state_e           w_tap_adv;
    tap_state_e           w_state_nxt;

    logic [3:0]           r_ir;
    logic [3:0]           r_ir_shift;
    logic [31:0]          r_id_shift;
    logic [USER_DR_W-1:0] r_user_shift;
    logic [USER_DR_W-1:0] r_user_wdata;
    logic [USER_DR_W-1:0] w_user_tdi_msb;
    logic                 r_byp_shift;
    logic                 r_tdo;
    logic                 r_wvalid;

    logic                 w_tms;
    logic                 w_tdi;
    logic                 w_jreset;
    logic                 w_tck_en;
    logic                 w_tck_rise;
    logic                 w_tck_fall;

    // All five JTAG inputs share one synchronizer depth so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 5'b0;
            r_sync2    <= 5'b0;
            r_tck_prev <= 1'b0;
        end else begin
            r_sync1    <= {jtag_reset, jtag_tckena, jtag_tdi, jtag_tms, jtag_tck};
            r_sync2    <= r_sync1;
            r_tck_prev <= r_sync2[0];
        end
    end

    assign w_tms    = r_sync2[1];
    assign w_tdi    = r_sync2[2];
    assign w_jreset = r_sync2[4];

`ifdef OFS_JTAG_TAP_SINK_TCKENA_EN
    assign w_tck_en = r_sync2[3];
`else
    // tckena still runs through its lane to keep the lanes identical, but it
    // gates nothing in this build.
    assign w_tck_en = r_sync2[3] | 1'b1;
`endif

    assign w_tck_rise = r_sync2[0] & ~r_tck_prev & w_tck_en;
    assign w_tck_fall = ~r_sync2[0] & r_tck_prev & w_tck_en;

    // TAP state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TAP next-state logic. jtag_reset overrides any simultaneous tck rise.
    always_comb begin
        w_tap_adv   = r_state;
        w_state_nxt = r_state;
        case (r_state)
            ST_TLR:    if (w_tms) w_tap_adv = ST_TLR;    else w_tap_adv = ST_RTI;
            ST_RTI:    if (w_tms) w_tap_adv = ST_SELDR;  else w_tap_adv = ST_RTI;
            ST_SELDR:  if (w_tms) w_tap_adv = ST_SELIR;  else w_tap_adv = ST_CAPDR;
            ST_CAPDR:  if (w_tms) w_tap_adv = ST_EX1DR;  else w_tap_adv = ST_SHDR;
            ST_SHDR:   if (w_tms) w_tap_adv = ST_EX1DR;  else w_tap_adv = ST_SHDR;
            ST_EX1DR:  if (w_tms) w_tap_adv = ST_UPDDR;  else w_tap_adv = ST_PAUSDR;
            ST_PAUSDR: if (w_tms) w_tap_adv = ST_EX2DR;  else w_tap_adv = ST_PAUSDR;
            ST_EX2DR:  if (w_tms) w_tap_adv = ST_UPDDR;  else w_tap_adv = ST_SHDR;
            ST_UPDDR:  if (w_tms) w_tap_adv = ST_SELDR;  else w_tap_adv = ST_RTI;
            ST_SELIR:  if (w_tms) w_tap_adv = ST_TLR;    else w_tap_adv = ST_CAPIR;
            ST_CAPIR:  if (w_tms) w_tap_adv = ST_EX1IR;  else w_tap_adv = ST_SHIR;
            ST_SHIR:   if (w_tms) w_tap_adv = ST_EX1IR;  else w_tap_adv = ST_SHIR;
            ST_EX1IR:  if (w_tms) w_tap_adv = ST_UPDIR;  else w_tap_adv = ST_PAUSIR;
            ST_PAUSIR: if (w_tms) w_tap_adv = ST_EX2IR;  else w_tap_adv = ST_PAUSIR;
            ST_EX2IR:  if (w_tms) w_tap_adv = ST_UPDIR;  else w_tap_adv = ST_SHIR;
            ST_UPDIR:  if (w_tms) w_tap_adv = ST_SELDR;  else w_tap_adv = ST_RTI;
            default:   w_tap_adv = ST_TLR;
        endcase
        if (w_jreset) begin
            w_state_nxt = ST_TLR;
        end else if (w_tck_rise) begin
            w_state_nxt = w_tap_adv;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // USER DR has a parameterised width, so tdi is placed at its MSB through
    // a mask rather than a concatenation (which would break at width 1).
    always_comb begin
        w_user_tdi_msb                = '0;
        w_user_tdi_msb[USER_DR_W-1]   = w_tdi;
    end

    // IR/DR capture, shift and update, tdo launch and the USER write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir         <= IR_IDCODE;
            r_ir_shift   <= 4'h0;
            r_id_shift   <= 32'h0;
            r_user_shift <= '0;
            r_byp_shift  <= 1'b0;
            r_user_wdata <= '0;
            r_wvalid     <= 1'b0;
            r_tdo        <= 1'b0;
        end else begin
            r_wvalid <= 1'b0;
            if (w_jreset) begin
                r_ir <= IR_IDCODE;
            end else begin
                if (w_tck_rise) begin
                    case (r_state)
                        ST_CAPIR: r_ir_shift <= 4'b0001;
                        ST_SHIR:  r_ir_shift <= {w_tdi, r_ir_shift[3:1]};
                        ST_UPDIR: r_ir       <= r_ir_shift;
                        ST_CAPDR: begin
                            case (r_ir)
                                IR_IDCODE: r_id_shift   <= IDCODE;
                                IR_USER:   r_user_shift <= user_dr_rdata;
                                default:   r_byp_shift  <= 1'b0;
                            endcase
                        end
                        ST_SHDR: begin
                            case (r_ir)
                                IR_IDCODE: r_id_shift   <= {w_tdi, r_id_shift[31:1]};
                                IR_USER:   r_user_shift <= (r_user_shift >> 1) | w_user_tdi_msb;
                                default:   r_byp_shift  <= w_tdi;
                            endcase
                        end
                        ST_UPDDR: begin
                            if (r_ir == IR_USER) begin
                                r_user_wdata <= r_user_shift;
                                r_wvalid     <= 1'b1;
                            end else begin
                                r_wvalid     <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                    // Entering TLR always reselects IDCODE.
                    if (w_tap_adv == ST_TLR) begin
                        r_ir <= IR_IDCODE;
                    end else begin
                        r_ir <= (r_state == ST_UPDIR) ? r_ir_shift : r_ir;
                    end
                end
                if (w_tck_fall) begin
                    if (r_state == ST_SHDR) begin
                        case (r_ir)
                            IR_IDCODE: r_tdo <= r_id_shift[0];
                            IR_USER:   r_tdo <= r_user_shift[0];
                            default:   r_tdo <= r_byp_shift;
                        endcase
                    end else if (r_state == ST_SHIR) begin
                        r_tdo <= r_ir_shift[0];
                    end else begin
                        r_tdo <= r_tdo;
                    end
                end
            end
        end
    end

    assign jtag_tdo       = r_tdo;
    assign user_dr_wdata  = r_user_wdata;
    assign user_dr_wvalid = r_wvalid;
    assign tap_state      = r_state;

endmodule

// File: tb/tb_ofs_jtag_tap_sink.sv
`timescale 1ns/1ps
module tb_ofs_jtag_tap_sink;

    localparam logic [31:0] TB_IDCODE = 32'h1234_5679;
    localparam int          W         = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         jtag_tck = 1'b0;
    logic         jtag_tms = 1'b0;
    logic         jtag_tdi = 1'b0;
    logic         jtag_tckena = 1'b1;
    logic         jtag_reset = 1'b0;
    logic         jtag_tdo;
    logic [W-1:0] user_dr_rdata = '0;
    logic [W-1:0] user_dr_wdata;
    logic         user_dr_wvalid;
    logic [3:0]   tap_state;

    ofs_jtag_tap_sink #(.IDCODE(TB_IDCODE), .USER_DR_W(W)) dut (
        .clk(clk), .rst(rst),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tckena(jtag_tckena), .jtag_reset(jtag_reset),
        .jtag_tdo(jtag_tdo),
        .user_dr_rdata(user_dr_rdata), .user_dr_wdata(user_dr_wdata),
        .user_dr_wvalid(user_dr_wvalid), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: number of clk cycles user_dr_wvalid was high, and the data seen.
    int           wv_count = 0;
    logic [W-1:0] wv_data  = '0;
    always @(negedge clk) begin
        if (user_dr_wvalid === 1'b1) begin
            wv_count <= wv_count + 1;
            wv_data  <= user_dr_wdata;
        end
    end

    // Reference model: TAP transition table plus abstract register contents.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int           m_state;
    logic [3:0]   m_ir;
    logic [3:0]   m_irsh;
    logic [63:0]  m_dr;
    int           m_len;
    logic         m_tdo;
    int           m_wv = 0;
    logic [W-1:0] m_wdata;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ir = 4'h1; m_irsh = 4'h0; m_dr = 64'h0;
        m_len = 1; m_tdo = 1'b0; m_wdata = '0;
    endtask

    task automatic pulse(input logic tms, input logic tdi);
        logic act;
        jtag_tms = tms;
        jtag_tdi = tdi;
        wait_clks(2);
        jtag_tck = 1'b1;
        wait_clks(4);
        jtag_tck = 1'b0;
        wait_clks(4);
`ifdef OFS_JTAG_TAP_SINK_TCKENA_EN
        act = jtag_tckena;
`else
        act = 1'b1;
`endif
        if (act) begin
            case (m_state)
                10: m_irsh = 4'b0001;
                11: m_irsh = {tdi, m_irsh[3:1]};
                15: m_ir = m_irsh;
                3: begin
                    if (m_ir == 4'h1) begin
                        m_dr = {32'h0, TB_IDCODE}; m_len = 32;
                    end else if (m_ir == 4'h8) begin
                        m_dr = 64'(user_dr_rdata); m_len = W;
                    end else begin
                        m_dr = 64'h0; m_len = 1;
                    end
                end
                4: m_dr = (m_dr >> 1) | (64'(tdi) << (m_len - 1));
                8: begin
                    if (m_ir == 4'h8) begin
                        m_wv++;
                        m_wdata = m_dr[W-1:0];
                    end
                end
                default: begin
                end
            endcase
            m_state = tms ? nxt1[m_state] : nxt0[m_state];
            if (m_state == 0) m_ir = 4'h1;
            if (m_state == 4) m_tdo = m_dr[0];
            else if (m_state == 11) m_tdo = m_irsh[0];
        end
        check("tap_state", 64'(tap_state), 64'(m_state));
        check("tdo", 64'(jtag_tdo), 64'(m_tdo));
        check("wvalid_count", 64'(wv_count), 64'(m_wv));
        check("wdata", 64'(user_dr_wdata), 64'(m_wdata));
    endtask

    task automatic jreset_pulse();
        jtag_reset = 1'b1;
        wait_clks(4);
        jtag_reset = 1'b0;
        wait_clks(4);
        m_state = 0;
        m_ir = 4'h1;
        check("jreset_tlr", 64'(tap_state), 64'd0);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = 64'h0;
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag_tdo;
            pulse(i == n - 1, din[i]);
        end
    endtask

    // From RTI: load an IR opcode and return to RTI.
    task automatic load_ir(input logic [3:0] op);
        logic [63:0] d;
        pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
        shift_bits(4, 64'(op), d);
        check("ir_capture", d, 64'h1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    task automatic goto_shdr();
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(tap_state), 64'd0);
        check({tag, "_tdo"}, 64'(jtag_tdo), 64'd0);
        check({tag, "_wvalid"}, 64'(user_dr_wvalid), 64'd0);
        check({tag, "_wdata"}, 64'(user_dr_wdata), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int v0;
        int k;

        // Reset
        rst = 1'b1;
        wait_clks(3);
        check_reset_outputs("reset");
        model_reset();
        rst = 1'b0;
        wait_clks(2);

        // IDCODE readout after reset
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        goto_shdr();
        shift_bits(32, 64'($urandom), d);
        check("idcode_shift", d, 64'(TB_IDCODE));
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);

        // Five tms=1 from RTI reaches TLR
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        check("rti_to_tlr", 64'(tap_state), 64'd0);
        pulse(1'b0, 1'b0);

        // BYPASS: one-bit delay with a leading 0
        load_ir(4'hF);
        goto_shdr();
        shift_bits(9, 64'hC3, d);
        check("bypass_delay", d, 64'h186);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);

        // USER: capture, shift and update pulse
        load_ir(4'h8);
        user_dr_rdata = 32'hDEAD_BEEF;
        goto_shdr();
        shift_bits(32, 64'h0000_0000_A5A5_0001, d);
        check("user_capture", d, 64'hDEAD_BEEF);
        v0 = wv_count;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        check("user_wvalid_once", 64'(wv_count), 64'(v0 + 1));
        check("user_wdata_seen", 64'(wv_data), 64'hA5A5_0001);

        // jtag_reset mid-ShDR under USER: no write, IR back to IDCODE
        goto_shdr();
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'($urandom_range(0, 1)));
        jreset_pulse();
        check("jreset_no_wvalid", 64'(wv_count), 64'(v0 + 1));
        pulse(1'b0, 1'b0);
        goto_shdr();
        shift_bits(32, 64'($urandom), d);
        check("jreset_ir_idcode", d, 64'(TB_IDCODE));
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);

        // rst mid-ShIR
        pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1); pulse(1'b0, 1'b0);
        rst = 1'b1;
        wait_clks(3);
        check_reset_outputs("midshift_rst");
        model_reset();
        rst = 1'b0;
        wait_clks(2);
        pulse(1'b0, 1'b0);
        check("restart_rti", 64'(tap_state), 64'd1);

        // tck edges with tckena low
        jtag_tckena = 1'b0;
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
`ifdef OFS_JTAG_TAP_SINK_TCKENA_EN
        check("tckena_hold", 64'(tap_state), 64'd1);
`else
        check("tckena_ignored", 64'(tap_state), 64'd0);
`endif
        jtag_tckena = 1'b1;
        pulse(1'b0, 1'b0);
        check("tckena_advance", 64'(tap_state), 64'd1);

        // Randomized walk against the model
        for (int i = 0; i < 300; i++) begin
            user_dr_rdata = $urandom;
            jtag_tckena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) jreset_pulse();
            else pulse($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
        end
        jtag_tckena = 1'b1;

        // From every one of the 16 states, five tms=1 reaches TLR
        for (int s = 0; s < 16; s++) begin
            k = 0;
            while (m_state != s && k < 300) begin
                user_dr_rdata = $urandom;
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                k++;
            end
            check("reach_state", 64'(tap_state), 64'(s));
            for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
            check("tlr_from_state", 64'(tap_state), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
